// File: rtl/dma_int_event_arbiter_pkg.sv
// Shared definitions for the DMA interrupt event arbiter.
package dma_int_event_arbiter_pkg;

   localparam int unsigned EVT_W  = 42;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned NUM_W  = 6;
   localparam int unsigned FLAG_W = 4;

   // Bit positions inside the flags nibble
   localparam int unsigned FLAG_OP_DONE   = 0;
   localparam int unsigned FLAG_WR_ERR    = 1;
   localparam int unsigned FLAG_RD_ERR    = 2;
   localparam int unsigned FLAG_INV_DSCR  = 3;

   // Descriptor numbers above the internal range 0..31
   localparam logic [NUM_W-1:0] DSCR_NUM_EXT    = 6'd32;
   localparam logic [NUM_W-1:0] DSCR_NUM_STREAM = 6'd33;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PUSH = 1'b1
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [NUM_W-1:0]  num;
      logic [FLAG_W-1:0] flags;
   } evt_word_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin selector: lowest requesting index at or above ptr, wrapping to 0.
module dma_rr_arbiter
   import dma_int_event_arbiter_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] winner,
   output logic             any
);

   logic found;

   // Scan N positions starting at ptr; first requester seen wins
   always_comb begin : sel
      int unsigned idx;
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      any    = |req;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            winner     = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dma_int_event_arbiter.sv
// Arbitrates per-requester DMA interrupt events into a single event FIFO port.
module dma_int_event_arbiter
   import dma_int_event_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned EVT_W   = dma_int_event_arbiter_pkg::EVT_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [32*NUM_REQ-1:0] req_addr,
   input  logic [6*NUM_REQ-1:0] req_num,
   input  logic [4*NUM_REQ-1:0] req_flags,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [EVT_W-1:0]     evt_data,
   output logic [15:0]          evt_count,
   output logic                 busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr, ptr_nxt;
   logic [NUM_REQ-1:0] grant, ack_nxt;
   logic [IDX_W-1:0]   winner;
   logic               any;
   logic               valid_nxt;
   logic [EVT_W-1:0]   data_nxt;
   logic [15:0]        cnt_nxt;
   evt_word_t          win_word;

   dma_rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .grant  (grant),
      .winner (winner),
      .any    (any)
   );

   // Gather the winning requester's slices into one event word
   always_comb begin
      win_word = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_word.addr  = req_addr[32*i +: 32];
            win_word.num   = req_num[6*i +: 6];
            win_word.flags = req_flags[4*i +: 4];
         end
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state: arbitrate only in IDLE, leave PUSH on FIFO acceptance
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any)                    state_nxt = ST_PUSH;
         ST_PUSH: if (evt_valid && evt_ready) state_nxt = ST_IDLE;
         default:                             state_nxt = ST_IDLE;
      endcase
   end

   // Output/datapath next values; everything holds unless an event moves
   always_comb begin
      ack_nxt   = '0;
      valid_nxt = evt_valid;
      data_nxt  = evt_data;
      cnt_nxt   = evt_count;
      ptr_nxt   = rr_ptr;
      case (state)
         ST_IDLE: begin
            if (any) begin
               ack_nxt   = grant;
               valid_nxt = 1'b1;
               data_nxt  = EVT_W'(win_word);
               ptr_nxt   = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_W'(1);
            end
         end
         ST_PUSH: begin
            if (evt_valid && evt_ready) begin
               valid_nxt = 1'b0;
               if (evt_count != 16'hFFFF) cnt_nxt = evt_count + 16'd1;
            end
         end
         default: ;
      endcase
   end

   // Output and pointer registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         req_ack   <= '0;
         evt_valid <= 1'b0;
         evt_data  <= '0;
         evt_count <= '0;
         busy      <= 1'b0;
      end else begin
         rr_ptr    <= ptr_nxt;
         req_ack   <= ack_nxt;
         evt_valid <= valid_nxt;
         evt_data  <= data_nxt;
         evt_count <= cnt_nxt;
         busy      <= (state_nxt == ST_PUSH);
      end
   end

endmodule

// File: tb/tb_dma_int_event_arbiter.sv
// Scoreboard bench for dma_int_event_arbiter.
module tb_dma_int_event_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned EW = 42;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [32*NR-1:0]  req_addr;
   logic [6*NR-1:0]   req_num;
   logic [4*NR-1:0]   req_flags;
   logic [NR-1:0]     req_ack;
   logic              evt_valid;
   logic              evt_ready;
   logic [EW-1:0]     evt_data;
   logic [15:0]       evt_count;
   logic              busy;

   dma_int_event_arbiter #(.NUM_REQ(NR), .EVT_W(EW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_num   (req_num),
      .req_flags (req_flags),
      .req_ack   (req_ack),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_data  (evt_data),
      .evt_count (evt_count),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Requester models: an event stays pending until its ack is observed
   int          post_cnt [NR];
   int          ack_cnt  [NR];
   logic [31:0] a_arr [NR];
   logic [5:0]  n_arr [NR];
   logic [3:0]  f_arr [NR];

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_valid[i]         = (post_cnt[i] != ack_cnt[i]);
         req_addr[32*i +: 32] = a_arr[i];
         req_num[6*i +: 6]    = n_arr[i];
         req_flags[4*i +: 4]  = f_arr[i];
      end
   end

   logic [EW-1:0] dq[$];
   logic [NR-1:0] aq[$];
   int            ack_cyc_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            preset_id   = 0;
   int            preset_seen = 0;
   logic [15:0]   exp_cnt  = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic post(input int i, input logic [31:0] a, input logic [5:0] n, input logic [3:0] f);
      a_arr[i] = a;
      n_arr[i] = n;
      f_arr[i] = f;
      dq.push_back({a, n, f});
      aq.push_back(NR'(1 << i));
      post_cnt[i]++;
   endtask

   task automatic cyc_wait();
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         cyc_wait();
         if (dq.size() == 0 && aq.size() == 0 && !evt_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("drain_timeout", 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: inputs are stable at the falling edge, so a handshake seen here happens at the next rising edge
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         exp_cnt = '0;
         dq.delete();
         aq.delete();
      end else begin
         if (preset_id != preset_seen) begin
            preset_seen = preset_id;
            exp_cnt     = 16'hFFFE;
         end
         check("evt_count", 64'(evt_count), 64'(exp_cnt));
         check("busy_vs_valid", 64'(busy), 64'(evt_valid));
         if (req_ack != '0) begin
            check("ack_onehot", 64'($onehot(req_ack)), 64'd1);
            check("ack_with_valid", 64'(evt_valid), 64'd1);
            if (aq.size() == 0) check("unexpected_ack", 64'(aq.size()), 64'd1);
            else                check("req_ack", 64'(req_ack), 64'(aq.pop_front()));
            for (int i = 0; i < NR; i++) if (req_ack[i]) ack_cnt[i]++;
            ack_cyc_q.push_back(cyc);
         end
         if (evt_valid && evt_ready) begin
            if (dq.size() == 0) check("unexpected_evt", 64'(dq.size()), 64'd1);
            else                check("evt_data", 64'(evt_data), 64'(dq.pop_front()));
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [EW-1:0] held;
      int n;
      reset     = 1'b1;
      evt_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         post_cnt[i] = 0; ack_cnt[i] = 0;
         a_arr[i] = '0; n_arr[i] = '0; f_arr[i] = '0;
      end
      do_reset();

      // Reset values
      check("rst_evt_valid", 64'(evt_valid), 64'd0);
      check("rst_req_ack",   64'(req_ack),   64'd0);
      check("rst_evt_data",  64'(evt_data),  64'd0);
      check("rst_evt_count", 64'(evt_count), 64'd0);
      check("rst_busy",      64'(busy),      64'd0);

      // Single requester, one register stage of latency
      post(2, 32'h1000_0040, 6'd5, 4'b0001);
      cyc_wait();
      check("single_ack",  64'(req_ack),  64'h4);
      check("single_data", 64'(evt_data), {22'd0, 32'h1000_0040, 6'd5, 4'b0001});
      check("single_busy", 64'(busy),     64'd1);
      drain();
      check("single_count", 64'(evt_count), 64'd1);

      // All four pending from reset: index order, one grant per two cycles
      do_reset();
      post(0, 32'hA000_0000, 6'd0,  4'b0001);
      post(1, 32'hA000_0010, 6'd31, 4'b0010);
      post(2, 32'hA000_0020, 6'd32, 4'b0100);
      post(3, 32'hA000_0030, 6'd33, 4'b1000);
      drain();
      n = ack_cyc_q.size();
      check("all4_ack_count", 64'(n >= 4), 64'd1);
      if (n >= 4)
         for (int k = n - 3; k < n; k++)
            check("all4_ack_gap", 64'(ack_cyc_q[k] - ack_cyc_q[k-1]), 64'd2);
      check("all4_count", 64'(evt_count), 64'd4);

      // Move pointer to 2 via requester 1, then 0 and 1 pending: 0 wins by wrap
      post(1, 32'hB000_0001, 6'd7, 4'b0011);
      drain();
      post(0, 32'hB000_0100, 6'd1, 4'b0001);
      post(1, 32'hB000_0200, 6'd2, 4'b0101);
      cyc_wait();
      check("wrap_first_ack", 64'(req_ack), 64'h1);
      drain();
      check("wrap_count", 64'(evt_count), 64'd7);

      // FIFO stall: event held stable, no further acks
      evt_ready = 1'b0;
      post(3, 32'hC0DE_F00D, 6'd33, 4'b1001);
      cyc_wait();
      held = evt_data;
      check("stall_data_first", 64'(held), {22'd0, 32'hC0DE_F00D, 6'd33, 4'b1001});
      for (int k = 0; k < 20; k++) begin
         cyc_wait();
         check("stall_valid", 64'(evt_valid), 64'd1);
         check("stall_busy",  64'(busy),      64'd1);
         check("stall_data",  64'(evt_data),  64'(held));
         check("stall_ack",   64'(req_ack),   64'd0);
      end
      evt_ready = 1'b1;
      drain();
      check("stall_count", 64'(evt_count), 64'd8);

      // Asynchronous reset in the middle of PUSH discards the event
      evt_ready = 1'b0;
      post(0, 32'hDEAD_0000, 6'd9, 4'b0110);
      cyc_wait();
      cyc_wait();
      #2;
      reset = 1'b1;
      #1;
      check("arst_evt_valid", 64'(evt_valid), 64'd0);
      check("arst_evt_count", 64'(evt_count), 64'd0);
      check("arst_busy",      64'(busy),      64'd0);
      check("arst_req_ack",   64'(req_ack),   64'd0);
      @(posedge clock);
      #1;
      reset     = 1'b0;
      evt_ready = 1'b1;
      repeat (5) cyc_wait();
      check("arst_no_reack", 64'(evt_valid), 64'd0);
      check("arst_count",    64'(evt_count), 64'd0);

      // Counter saturation
      force dut.evt_count = 16'hFFFE;
      preset_id++;
      #1;
      release dut.evt_count;
      post(1, 32'hE000_0001, 6'd1, 4'b0001);
      post(2, 32'hE000_0002, 6'd2, 4'b0001);
      post(3, 32'hE000_0003, 6'd3, 4'b0001);
      drain();
      check("sat_count", 64'(evt_count), 64'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
